// File: rtl/dmem_responder.sv
// Data-port responder: byte-lane RAM, 64-bit cycle counter and TX FIFO.
// Read data is registered and read-first; FIFO drains over valid/ready.
module dmem_responder #(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_C = (FW+1)'(FIFO_DEPTH);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [31:0]   rd_q, rd_d;
  logic [63:0]   cnt_q;
  logic [31:0]   hi_q, hi_d;
  logic [FW-1:0] head_q, tail_q;
  logic [FW:0]   count_q;
  logic          ovf_q;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] widx;
  logic [1:0]    sel;
  logic          full, empty, pop, push_req, push;
  logic          ovf_set, ovf_clr;
  logic          unused;

  assign unused   = ^d_addr[1:0];
  assign ram_hit  = d_addr[31:AW+2] == '0;
  assign mmio_hit = d_addr[31:4] == MMIO_BASE[31:4];
  assign widx     = d_addr[AW+1:2];
  assign sel      = d_addr[3:2];

  assign empty    = count_q == '0;
  assign full     = count_q == FULL_C;
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo_q[head_q];
  assign pop      = tx_valid && tx_ready;
  assign push_req = !rst && mmio_hit && sel == 2'd2 && d_we[0];
  // A full FIFO still accepts a push when the head leaves this cycle
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = mmio_hit && sel == 2'd3
                 && d_we[0] && d_wr_data[2];

  always_comb begin
    rd_d = '0;
    hi_d = hi_q;
    unique case (1'b1)
      ram_hit:  rd_d = mem_q[widx];
      mmio_hit: begin
        unique case (sel)
          2'd0: begin
            rd_d = cnt_q[31:0];
            hi_d = cnt_q[63:32];
          end
          2'd1: rd_d = hi_q;
          2'd2: rd_d = '0;
          2'd3: rd_d = {24'd0, 4'(count_q), 1'b0,
                        ovf_q, empty, full};
          default: rd_d = '0;
        endcase
      end
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      cnt_q <= cnt_q + 64'd1;
      hi_q  <= hi_d;
      if (pop)  head_q <= head_q + 1'b1;
      if (push) tail_q <= tail_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (d_we[i]) mem_q[widx][8*i +: 8] <= d_wr_data[8*i +: 8];
      end
    end
    if (push) fifo_q[tail_q] <= d_wr_data[7:0];
  end

  assign d_rd_data = rd_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic
// checked cycle by cycle against a queue/array reference model.
module tb_dmem_responder;

  localparam int WORDS = 1024;
  localparam int DEPTH = 4;
  localparam logic [31:0] IDLE = 32'h4000_0000;
  localparam logic [31:0] CLO  = 32'h8000_0000;
  localparam logic [31:0] CHI  = 32'h8000_0004;
  localparam logic [31:0] TXD  = 32'h8000_0008;
  localparam logic [31:0] STS  = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mref [WORDS];
  logic [7:0]  q [$];
  logic [63:0] cnt;
  logic [31:0] hi;
  logic        ovf;

  dmem_responder #(
    .MEM_WORDS(WORDS), .MMIO_BASE(32'h8000_0000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .d_addr(d_addr), .d_we(d_we),
    .d_wr_data(d_wr_data), .d_rd_data(d_rd_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input logic rdy,
                      input logic r);
    logic [31:0] exp;
    logic ram, mmio, pop, psh;
    int o;
    rst = r; d_addr = a; d_we = we; d_wr_data = wd; tx_ready = rdy;
    exp = '0;
    ram = a < 32'(WORDS * 4);
    mmio = a[31:4] == 28'h800_0000;
    o = int'(a[3:2]);
    if (r) begin
      q.delete(); cnt = '0; hi = '0; ovf = 1'b0;
    end else begin
      if (ram) exp = mref[a[11:2]];
      else if (mmio) begin
        case (o)
          0: begin exp = cnt[31:0]; hi = cnt[63:32]; end
          1: exp = hi;
          3: exp = {24'd0, 4'(q.size()), 1'b0, ovf,
                    q.size() == 0, q.size() == DEPTH};
          default: exp = '0;
        endcase
      end
      pop = q.size() > 0 && rdy;
      psh = mmio && o == 2 && we[0];
      if (psh && q.size() == DEPTH && !pop) ovf = 1'b1;
      else begin
        if (pop) void'(q.pop_front());
        if (psh) q.push_back(wd[7:0]);
      end
      if (mmio && o == 3 && we[0] && wd[2]) ovf = 1'b0;
      if (ram)
        for (int i = 0; i < 4; i++)
          if (we[i]) mref[a[11:2]][8*i +: 8] = wd[8*i +: 8];
      cnt = cnt + 64'd1;
    end
    @(posedge clk);
    #1;
    chk("rd_data", d_rd_data, exp);
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    chk("tx_data", 32'(tx_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0] s5 [4];
    s5 = '{8'h42, 8'h43, 8'h44, 8'h55};

    step(IDLE, 4'h0, 0, 1'b0, 1'b1);
    step(IDLE, 4'h0, 0, 1'b0, 1'b1);
    chk("reset_rd", d_rd_data, 32'd0);
    chk("reset_valid", 32'(tx_valid), 32'd0);
    for (int i = 0; i < WORDS; i++) step(32'(i * 4), 4'hF, 0, 1'b0, 1'b0);

    // byte lanes
    step(32'h10, 4'hF, 32'h1122_3344, 1'b0, 1'b0);
    step(32'h10, 4'b0101, 32'hAABB_CCDD, 1'b0, 1'b0);
    step(32'h10, 4'h0, 0, 1'b0, 1'b0);
    chk("lanes", d_rd_data, 32'h11BB_33DD);

    // read-first and unmapped
    step(32'h20, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rf_old", d_rd_data, 32'd0);
    step(32'h20, 4'h0, 0, 1'b0, 1'b0);
    chk("rf_new", d_rd_data, 32'hDEAD_BEEF);
    step(IDLE, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
    step(IDLE, 4'h0, 0, 1'b0, 1'b0);
    chk("unmapped", d_rd_data, 32'd0);

    // counter after reset
    step(IDLE, 4'h0, 0, 1'b0, 1'b1);
    step(IDLE, 4'h0, 0, 1'b0, 1'b1);
    repeat (10) step(IDLE, 4'h0, 0, 1'b0, 1'b0);
    step(CLO, 4'h0, 0, 1'b0, 1'b0);
    chk("cnt_lo", d_rd_data, 32'd10);
    step(CHI, 4'h0, 0, 1'b0, 1'b0);
    chk("cnt_hi", d_rd_data, 32'd0);

    // fill and overflow
    for (int i = 0; i < 5; i++)
      step(TXD, 4'h1, 32'(8'h41 + i), 1'b0, 1'b0);
    step(STS, 4'h0, 0, 1'b0, 1'b0);
    chk("sts_full", d_rd_data, 32'h45);
    chk("head", 32'(tx_data), 32'h41);
    step(STS, 4'h1, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain4", 32'(tx_data), 32'(8'h41 + i));
      step(IDLE, 4'h0, 0, 1'b1, 1'b0);
    end
    chk("drained", 32'(tx_valid), 32'd0);
    step(STS, 4'h0, 0, 1'b1, 1'b0);
    chk("sts_empty", d_rd_data, 32'h02);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      step(TXD, 4'h1, 32'(8'h41 + i), 1'b0, 1'b0);
    chk("head5", 32'(tx_data), 32'h41);
    step(TXD, 4'h1, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain5", 32'(tx_data), 32'(s5[i]));
      step(IDLE, 4'h0, 0, 1'b1, 1'b0);
    end
    step(STS, 4'h0, 0, 1'b1, 1'b0);
    chk("no_ovf", d_rd_data, 32'h02);

    // reset mid-drain
    for (int i = 0; i < 3; i++)
      step(TXD, 4'h1, 32'(8'h61 + i), 1'b0, 1'b0);
    step(TXD, 4'h1, 32'h70, 1'b1, 1'b1);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_rd", d_rd_data, 32'd0);
    step(STS, 4'h0, 0, 1'b1, 1'b0);
    chk("rst_sts", d_rd_data, 32'h02);
    step(CLO, 4'h0, 0, 1'b1, 1'b0);
    chk("rst_cnt", d_rd_data, 32'd1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 5)
        a = {20'd0, 10'($urandom), 2'($urandom)};
      else if (k < 9)
        a = {28'h800_0000, 2'($urandom), 2'($urandom)};
      else
        a = {16'h4000, 16'($urandom)};
      step(a, 4'($urandom), $urandom, 1'($urandom),
           $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
